mac_result_collector: RTL
=========================

Name: mac_result_collector

Overview:
- Sits directly downstream of the MAC array.
- Consumes the four signed accumulator outputs and the per-lane `valid_out` strobes.
- Gathers one value per lane into a row, requantizes each lane (arithmetic shift, then saturation to W bits), and buffers complete rows in a small FIFO.
- Streams the results one lane at a time over a valid/ready interface to the writeback/next-layer logic.

Parameters:
- W, 8, output data width (signed).
- ACC_W, 16, accumulator input width (signed).
- N_MACS, 4, number of lanes per row; fixed at 4 to match the four acc ports.
- DEPTH, 4, FIFO depth in rows; power of 2, ≥2.
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush of lane flags, FIFO, stream index, overflow, counters
- shift  in  4  requantization right-shift amount; sampled at row commit
- acc_in_0..acc_in_3  in  ACC_W each  signed accumulators from the MAC array
- valid_in  in  N_MACS  per-lane capture strobe
- out_data  out  W  signed quantized lane value
- out_lane  out  2  lane index of out_data
- out_last  out  1  high on the last lane of a row
- out_valid  out  1  output handshake valid
- out_ready  in  1  output handshake ready
- busy  out  1  any lane flag set or FIFO non-empty
- overflow  out  1  sticky error flag
- row_count  out  CNT_W  rows fully streamed out; wraps
- sat_count  out  CNT_W  lanes saturated at commit; saturates at all-ones

Behaviour:
- Reset/clear values: all outputs 0, lane flags 0, FIFO empty, stream index 0. rst has priority over clear.
- Capture:
  - valid_in[i]=1 with flag[i]=0: latch acc_in_i and set flag[i].
  - valid_in[i]=1 with flag[i]=1 (lane overrun): new value dropped, overflow set.
- Commit:
  - Triggered in the cycle where (flag | valid_in) is all ones. Incoming values bypass the capture registers.
  - Each lane: q = acc >>> shift (arithmetic), then saturate to [-2^(W-1), 2^(W-1)-1]. sat_count increments by the number of lanes clipped.
  - The row is pushed at that clock edge and all flags clear.
  - A valid_in on an already-flagged lane in the commit cycle counts as an overrun, not as the start of the next row.
- FIFO full at commit:
  - If a pop (final-lane handshake) occurs in the same cycle, the push is accepted.
  - Otherwise the row is dropped and overflow is set. Flags still clear.
- Output FSM:
  - IDLE: FIFO empty, out_valid=0. Moves to STREAM when non-empty.
  - STREAM: out_valid=1; out_data/out_lane show lane idx of the head row.
    - On out_valid&out_ready: idx increments.
    - When idx=N_MACS-1 (out_last=1): pop, idx resets to 0, row_count increments; return to IDLE if the FIFO becomes empty.
- Latency: commit edge at cycle T → out_valid=1 in cycle T+1 when the FIFO was empty. No combinational path from valid_in to out_*.
- out_data and out_lane stay stable while out_valid=1 and out_ready=0.
- Mid-stream clear: the current row is abandoned and out_valid drops the next cycle.
- shift ≥ ACC_W yields 0 or -1 (sign fill).

Optional Feature:
- Macro: MAC_RESULT_RELU_EN.
- Defined: negative pre-saturation values are forced to 0 before saturation (ReLU). Saturation upper bound is unchanged. Negative lanes do not count toward sat_count.
- Undefined: signed passthrough as above.

Decomposition:
- Package mac_result_pkg:
  - LANE_W=2.
  - Output-FSM state enum {ST_IDLE, ST_STREAM}.
  - Constants QMAX/QMIN derived from W.
  - Function sat_shift(acc, shift) returning W bits plus a clip bit.
- Sub-module result_row_fifo:
  - Parameterized width N_MACS*W, DEPTH.
  - Push/pop with simultaneous push-on-full allowed when popping.
  - Ports full, empty, head.

Test Plan:
- shift=2; lanes 0..3 strobed in one cycle with 100, 1000, -600, -4 → stream 25, 127, -128, -1; out_lane 0..3; out_last on lane 3; sat_count=2; row_count=1.
- Lanes strobed in cycles 1,3,3,7 with values 8,16,24,32 at shift=3 → single commit at cycle 7; out_valid first high at cycle 8 with 1, then 2, 3, 4.
- valid_in[1] pulsed twice before lane 3 arrives → overflow=1; lane 1 carries the first value; row still streams.
- out_ready=0, then DEPTH+1 complete rows pushed → first DEPTH rows retained, last dropped, overflow=1. Release out_ready → exactly DEPTH*4 beats; row_count=DEPTH.
- FIFO full and final-lane pop in the same cycle as a commit → push accepted, overflow stays 0.
- With MAC_RESULT_RELU_EN: -600 at shift 2 → 0, sat_count unchanged. clear asserted mid-stream → out_valid=0 next cycle, busy=0, counters 0.

Source files
------------

// File: rtl/mac_result_collector_pkg.sv
// Shared types and requantization helper for the MAC result collector.
// MAC_RESULT_RELU_EN: when defined, negative lanes are clamped to zero before saturation.
package mac_result_pkg;

  localparam int DATA_W = 8;
  localparam int LANE_W = 2;
  localparam int QMAX   = (1 << (DATA_W - 1)) - 1;
  localparam int QMIN   = -(1 << (DATA_W - 1));

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  typedef struct packed {
    logic signed [DATA_W-1:0] q;
    logic                     clip;
  } sat_t;

  function automatic sat_t sat_shift(input logic signed [31:0] acc, input logic [3:0] shift);
    sat_t r;
    logic signed [31:0] q;
    q = acc >>> shift;
`ifdef MAC_RESULT_RELU_EN
    if (q < 0) q = '0;
`endif
    r.clip = 1'b0;
    r.q    = q[DATA_W-1:0];
    if (q > QMAX) begin
      r.q    = DATA_W'(QMAX);
      r.clip = 1'b1;
    end else if (q < QMIN) begin
      r.q    = DATA_W'(QMIN);
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_result_collector_if.sv
// Lane-serial result stream between the collector and the writeback logic.
interface mac_result_collector_if
  import mac_result_pkg::*;
#(
  parameter int W = DATA_W
);
  logic signed [W-1:0]      out_data;
  logic        [LANE_W-1:0] out_lane;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;

  modport master (output out_data, out_lane, out_last, out_valid, input out_ready);
  modport slave  (input out_data, out_lane, out_last, out_valid, output out_ready);
endinterface

// File: rtl/mac_result_collector_fifo.sv
// Row FIFO; a push while full is accepted when the head is popped in the same cycle.
module result_row_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mac_result_collector.sv
// Gathers one accumulator per lane into a row, requantizes, buffers and streams lane by lane.
// Optional build macro MAC_RESULT_RELU_EN selects ReLU requantization (see package).
//   state     | meaning
//   ST_IDLE   | FIFO empty, nothing offered
//   ST_STREAM | head row offered, lane idx on the bus
module mac_result_collector
  import mac_result_pkg::*;
#(
  parameter int W      = DATA_W,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [3:0]              shift,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  input  logic [N_MACS-1:0]       valid_in,
  mac_result_collector_if.master  st,
  output logic                    busy,
  output logic                    overflow,
  output logic [CNT_W-1:0]        row_count,
  output logic [CNT_W-1:0]        sat_count
);
  localparam int AW  = $clog2(DEPTH);
  localparam int NCW = $clog2(N_MACS + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_MACS - 1);

  logic signed [ACC_W-1:0] acc_in   [N_MACS];
  logic signed [ACC_W-1:0] acc_q    [N_MACS];
  logic signed [ACC_W-1:0] lane_val [N_MACS];
  sat_t                    sat      [N_MACS];
  logic [N_MACS-1:0]       flags;
  logic [N_MACS*W-1:0]     row, head;
  logic [NCW-1:0]          n_clip;
  logic [CNT_W:0]          sat_sum;
  logic                    commit, pop, push_drop, full, empty;
  logic [AW:0]             level;
  logic [0:0]              state;
  logic [LANE_W-1:0]       idx;

  assign acc_in[0] = acc_in_0;
  assign acc_in[1] = acc_in_1;
  assign acc_in[2] = acc_in_2;
  assign acc_in[3] = acc_in_3;

  // A strobe arriving in the completing cycle joins the row directly.
  assign commit = &(flags | valid_in);

  always_comb begin
    lane_val = '{default: '0};
    sat      = '{default: '0};
    row      = '0;
    n_clip   = '0;
    for (int i = 0; i < N_MACS; i++) begin
      lane_val[i]    = flags[i] ? acc_q[i] : acc_in[i];
      sat[i]         = sat_shift(32'(lane_val[i]), shift);
      row[i*W +: W]  = sat[i].q;
      n_clip         = n_clip + NCW'(sat[i].clip);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear)  flags <= '0;
    else if (commit)   flags <= '0;
    else               flags <= flags | valid_in;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_MACS; i++)
      if (valid_in[i] && !flags[i]) acc_q[i] <= acc_in[i];
  end

  assign pop       = st.out_valid & st.out_ready & (idx == LAST_LANE);
  assign push_drop = commit & full & ~pop;
  assign sat_sum   = {1'b0, sat_count} + (CNT_W+1)'(n_clip);

  result_row_fifo #(.WIDTH(N_MACS*W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (commit),
    .pop   (pop),
    .din   (row),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overflow  <= 1'b0;
      row_count <= '0;
      sat_count <= '0;
    end else begin
      if (|(flags & valid_in) || push_drop) overflow <= 1'b1;
      if (pop)    row_count <= row_count + 1'b1;
      if (commit) sat_count <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (commit || !empty) state <= ST_STREAM;
        default:
          if (st.out_ready) begin
            if (idx == LAST_LANE) begin
              idx <= '0;
              if (level == (AW+1)'(1) && !commit) state <= ST_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
      endcase
    end
  end

  assign st.out_valid = (state == ST_STREAM);
  assign st.out_lane  = st.out_valid ? idx : '0;
  assign st.out_data  = st.out_valid ? head[idx*W +: W] : '0;
  assign st.out_last  = st.out_valid & (idx == LAST_LANE);
  assign busy         = (|flags) | ~empty;
endmodule
